// File: rtl/mem_port_arbiter.sv
// Shares the single DPI load/store memory port between IFU and LSU.
// One outstanding transaction; optional wait cycles emulate slow memory.
module mem_port_arbiter #(
   parameter int unsigned LATENCY = 0,
   parameter bit          RR_ARB  = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_resp_valid,
   input  logic        ifu_resp_ready,
   output logic [31:0] ifu_resp_data,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic        lsu_req_wen,
   input  logic [31:0] lsu_req_addr,
   input  logic [31:0] lsu_req_wdata,
   input  logic [7:0]  lsu_req_wmask,
   output logic        lsu_resp_valid,
   input  logic        lsu_resp_ready,
   output logic [31:0] lsu_resp_data,
   output logic        mem_ld_wen,
   output logic        mem_st_wen,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPT,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] LAT_M1 =
      (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);
   localparam bit HAS_WAIT = (LATENCY != 0);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        wen_q, wen_d;
   logic        ld_q, ld_d;
   logic        st_q, st_d;
   logic [31:0] raddr_q, raddr_d;
   logic [31:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;

   logic is_idle;
   logic in_resp;
   logic grant_lsu;
   logic resp_ok;
   logic hs;
   logic req_wen;
   logic [31:0] req_addr;

   // owner_q / last_q: 1 = LSU, 0 = IFU
   assign is_idle   = reset && (state_q == S_IDLE);
   assign in_resp   = reset && (state_q == S_RESP);
   assign grant_lsu = lsu_req_valid &&
                      (!ifu_req_valid || !RR_ARB || !last_q);

   assign lsu_req_ready = is_idle && grant_lsu;
   assign ifu_req_ready = is_idle && ifu_req_valid && !grant_lsu;
   assign hs            = ifu_req_ready || lsu_req_ready;
   assign req_wen       = lsu_req_ready && lsu_req_wen;
   assign req_addr      = lsu_req_ready ? lsu_req_addr : ifu_req_addr;

   assign ifu_resp_valid = in_resp && !owner_q;
   assign lsu_resp_valid = in_resp && owner_q;
   assign ifu_resp_data  = rbuf_q;
   assign lsu_resp_data  = rbuf_q;
   assign resp_ok        = owner_q ? lsu_resp_ready : ifu_resp_ready;

   assign mem_ld_wen = reset && ld_q;
   assign mem_st_wen = reset && st_q;
   assign mem_raddr  = raddr_q;
   assign mem_waddr  = waddr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wmask  = wmask_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      owner_d = owner_q;
      last_d  = last_q;
      wen_d   = wen_q;
      ld_d    = 1'b0;
      st_d    = 1'b0;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      unique case (state_q)
         S_IDLE: begin
            if (hs) begin
               state_d = S_ISSUE;
               owner_d = lsu_req_ready;
               last_d  = lsu_req_ready;
               wen_d   = req_wen;
               ld_d    = !req_wen;
               st_d    = req_wen;
               raddr_d = req_addr;
               waddr_d = req_addr;
               wdata_d = lsu_req_ready ? lsu_req_wdata : 32'h0;
               wmask_d = lsu_req_ready ? lsu_req_wmask : 8'h0;
            end
         end
         S_ISSUE: state_d = S_CAPT;
         S_CAPT: begin
            rbuf_d  = wen_q ? 32'h0 : mem_rdata;
            cnt_d   = LAT_M1;
            state_d = HAS_WAIT ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_RESP: begin
            if (resp_ok) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         rbuf_q  <= 32'h0;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         wen_q   <= 1'b0;
         ld_q    <= 1'b0;
         st_q    <= 1'b0;
         raddr_q <= 32'h0;
         waddr_q <= 32'h0;
         wdata_q <= 32'h0;
         wmask_q <= 8'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         wen_q   <= wen_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RR lat0, fixed lat0, RR lat5),
// each with its own small word memory model.
module tb_mem_port_arbiter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        ifu_req_valid  [3];
   logic        ifu_req_ready  [3];
   logic [31:0] ifu_req_addr   [3];
   logic        ifu_resp_valid [3];
   logic        ifu_resp_ready [3];
   logic [31:0] ifu_resp_data  [3];
   logic        lsu_req_valid  [3];
   logic        lsu_req_ready  [3];
   logic        lsu_req_wen    [3];
   logic [31:0] lsu_req_addr   [3];
   logic [31:0] lsu_req_wdata  [3];
   logic [7:0]  lsu_req_wmask  [3];
   logic        lsu_resp_valid [3];
   logic        lsu_resp_ready [3];
   logic [31:0] lsu_resp_data  [3];
   logic        mem_ld_wen     [3];
   logic        mem_st_wen     [3];
   logic [31:0] mem_raddr      [3];
   logic [31:0] mem_waddr      [3];
   logic [31:0] mem_wdata      [3];
   logic [7:0]  mem_wmask      [3];
   logic [31:0] mem_rdata      [3];

   logic [31:0] mem [3][2048];

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int n0, n1, lat;
   logic seen;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_port_arbiter #(
         .LATENCY(g == 2 ? 5 : 0),
         .RR_ARB (g == 1 ? 0 : 1)
      ) u_dut (
         .clock         (clock),
         .reset         (reset),
         .ifu_req_valid (ifu_req_valid[g]),
         .ifu_req_ready (ifu_req_ready[g]),
         .ifu_req_addr  (ifu_req_addr[g]),
         .ifu_resp_valid(ifu_resp_valid[g]),
         .ifu_resp_ready(ifu_resp_ready[g]),
         .ifu_resp_data (ifu_resp_data[g]),
         .lsu_req_valid (lsu_req_valid[g]),
         .lsu_req_ready (lsu_req_ready[g]),
         .lsu_req_wen   (lsu_req_wen[g]),
         .lsu_req_addr  (lsu_req_addr[g]),
         .lsu_req_wdata (lsu_req_wdata[g]),
         .lsu_req_wmask (lsu_req_wmask[g]),
         .lsu_resp_valid(lsu_resp_valid[g]),
         .lsu_resp_ready(lsu_resp_ready[g]),
         .lsu_resp_data (lsu_resp_data[g]),
         .mem_ld_wen    (mem_ld_wen[g]),
         .mem_st_wen    (mem_st_wen[g]),
         .mem_raddr     (mem_raddr[g]),
         .mem_waddr     (mem_waddr[g]),
         .mem_wdata     (mem_wdata[g]),
         .mem_wmask     (mem_wmask[g]),
         .mem_rdata     (mem_rdata[g])
      );
   end

   // Memory answers the cycle after the load strobe edge
   always @(posedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            mem[k][0] <= 32'h0000_0413;
         end else begin
            if (mem_st_wen[k]) begin
               for (int b = 0; b < 4; b++) begin
                  if (mem_wmask[k][b]) begin
                     mem[k][mem_waddr[k][12:2]][8*b +: 8] <=
                        mem_wdata[k][8*b +: 8];
                  end
               end
            end
            if (mem_ld_wen[k]) begin
               mem_rdata[k] <= mem[k][mem_raddr[k][12:2]];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   function automatic logic [31:0] gcode(input int k);
      if (lsu_req_ready[k] && ifu_req_ready[k]) return 32'd2;
      if (lsu_req_ready[k]) return 32'd1;
      return 32'd0;
   endfunction

   function automatic logic [31:0] outs(input int k);
      return 32'({ifu_req_ready[k], lsu_req_ready[k],
                  ifu_resp_valid[k], lsu_resp_valid[k],
                  mem_ld_wen[k], mem_st_wen[k]});
   endfunction

   function automatic logic [31:0] strb(input int k);
      return 32'({mem_ld_wen[k], mem_st_wen[k]});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ifu_req_valid[k]  = 1'b0;
         ifu_req_addr[k]   = 32'h0;
         ifu_resp_ready[k] = 1'b0;
         lsu_req_valid[k]  = 1'b0;
         lsu_req_wen[k]    = 1'b0;
         lsu_req_addr[k]   = 32'h0;
         lsu_req_wdata[k]  = 32'h0;
         lsu_req_wmask[k]  = 8'h0;
         lsu_resp_ready[k] = 1'b0;
         mem_rdata[k]      = 32'h0;
      end
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         ifu_req_valid[k]  = 1'b1;
         ifu_req_addr[k]   = 32'h8000_0000;
         lsu_req_valid[k]  = 1'b1;
         lsu_req_addr[k]   = 32'h8000_0100;
         ifu_resp_ready[k] = 1'b1;
         lsu_resp_ready[k] = 1'b1;
      end
      #1;
      chk("rst_outs0", outs(0), 32'h0);
      chk("rst_outs1", outs(1), 32'h0);
      chk("rst_raddr", mem_raddr[0], 32'h0);
      chk("rst_waddr", mem_waddr[0], 32'h0);
      chk("rst_wdata", mem_wdata[0], 32'h0);
      chk("rst_wmask", 32'(mem_wmask[0]), 32'h0);
      chk("rst_rdata", ifu_resp_data[0] | lsu_resp_data[0], 32'h0);

      // Both requesters valid every cycle
      step();
      reset = 1'b1;
      #1;
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) begin
            step();
            #1;
         end
         if (ifu_req_ready[0] || lsu_req_ready[0]) begin
            if (n0 < 4) chk("rr_grant", gcode(0), (n0 % 2 == 0) ? 1 : 0);
            n0++;
         end
         if (ifu_req_ready[1] || lsu_req_ready[1]) begin
            if (n1 < 4) chk("fp_grant", gcode(1), 32'd1);
            n1++;
         end
         if (n0 >= 4 && n1 >= 4) break;
      end
      chk("rr_grant_count", n0, 4);
      chk("fp_grant_count", n1, 4);
      step();
      for (int k = 0; k < 2; k++) begin
         ifu_req_valid[k] = 1'b0;
         lsu_req_valid[k] = 1'b0;
      end
      repeat (6) step();
      for (int k = 0; k < 2; k++) begin
         ifu_resp_ready[k] = 1'b0;
         lsu_resp_ready[k] = 1'b0;
      end
      #1;
      chk("drained", outs(0) | outs(1), 32'h0);

      // IFU read, LATENCY=0
      step();
      ifu_req_valid[0] = 1'b1;
      ifu_req_addr[0]  = 32'h8000_0000;
      #1;
      chk("ifu_req_ready", ifu_req_ready[0], 1);
      step();
      ifu_req_valid[0] = 1'b0;
      ifu_req_addr[0]  = 32'h1234_5678;
      #1;
      chk("ifu_ld_strobe", strb(0), 32'h2);
      chk("ifu_raddr", mem_raddr[0], 32'h8000_0000);
      step();
      #1;
      chk("ifu_strobe_once", strb(0), 32'h0);
      chk("ifu_no_early_resp", ifu_resp_valid[0], 0);
      step();
      ifu_resp_ready[0] = 1'b1;
      #1;
      chk("ifu_resp_valid", 32'({ifu_resp_valid[0], lsu_resp_valid[0]}),
          32'h2);
      chk("ifu_resp_data", ifu_resp_data[0], 32'h0000_0413);
      step();
      ifu_resp_ready[0] = 1'b0;
      #1;
      chk("ifu_resp_done", ifu_resp_valid[0], 0);

      // LSU store then load back
      step();
      lsu_req_valid[0] = 1'b1;
      lsu_req_wen[0]   = 1'b1;
      lsu_req_addr[0]  = 32'h8000_1000;
      lsu_req_wdata[0] = 32'hDEAD_BEEF;
      lsu_req_wmask[0] = 8'h0F;
      #1;
      chk("st_req_ready", lsu_req_ready[0], 1);
      step();
      lsu_req_valid[0] = 1'b0;
      lsu_req_wdata[0] = 32'h0;
      #1;
      chk("st_strobe", strb(0), 32'h1);
      chk("st_waddr", mem_waddr[0], 32'h8000_1000);
      chk("st_wdata", mem_wdata[0], 32'hDEAD_BEEF);
      chk("st_wmask", 32'(mem_wmask[0]), 32'h0F);
      step();
      #1;
      chk("st_strobe_once", strb(0), 32'h0);
      step();
      lsu_resp_ready[0] = 1'b1;
      #1;
      chk("st_resp_valid", 32'({ifu_resp_valid[0], lsu_resp_valid[0]}),
          32'h1);
      chk("st_resp_data", lsu_resp_data[0], 32'h0);
      step();
      lsu_resp_ready[0] = 1'b0;
      lsu_req_valid[0]  = 1'b1;
      lsu_req_wen[0]    = 1'b0;
      #1;
      chk("ld_back_ready", lsu_req_ready[0], 1);
      step();
      lsu_req_valid[0] = 1'b0;
      #1;
      chk("ld_back_strobe", strb(0), 32'h2);
      chk("ld_back_raddr", mem_raddr[0], 32'h8000_1000);
      step();
      step();
      lsu_resp_ready[0] = 1'b1;
      #1;
      chk("ld_back_valid", lsu_resp_valid[0], 1);
      chk("ld_back_data", lsu_resp_data[0], 32'hDEAD_BEEF);
      step();
      lsu_resp_ready[0] = 1'b0;

      // LATENCY=5 with back-pressure
      step();
      ifu_req_valid[2] = 1'b1;
      ifu_req_addr[2]  = 32'h8000_0000;
      #1;
      chk("lat_req_ready", ifu_req_ready[2], 1);
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) ifu_req_valid[2] = 1'b0;
         #1;
         chk("lat_no_resp", ifu_resp_valid[2], 0);
      end
      for (int c = 8; c <= 11; c++) begin
         step();
         ifu_req_valid[2] = 1'b1;
         lsu_req_valid[2] = 1'b1;
         lsu_req_addr[2]  = 32'h8000_1000;
         #1;
         chk("lat_resp_hold", ifu_resp_valid[2], 1);
         chk("lat_resp_data", ifu_resp_data[2], 32'h0000_0413);
         chk("lat_no_ready", 32'({ifu_req_ready[2], lsu_req_ready[2]}), 0);
      end
      step();
      ifu_resp_ready[2] = 1'b1;
      ifu_req_valid[2]  = 1'b0;
      #1;
      chk("lat_resp_final", ifu_resp_valid[2], 1);
      chk("lat_no_ready_hs", lsu_req_ready[2], 0);
      step();
      ifu_resp_ready[2] = 1'b0;
      #1;
      chk("lat_resp_gone", ifu_resp_valid[2], 0);
      chk("lat_next_accept", lsu_req_ready[2], 1);
      step();
      lsu_req_valid[2] = 1'b0;
      #1;
      chk("lat_ld_strobe", strb(2), 32'h2);

      // Reset while counting down in WAIT
      step();
      step();
      step();
      reset = 1'b0;
      lsu_resp_ready[2] = 1'b1;
      #1;
      chk("wrst_outs", outs(2), 32'h0);
      step();
      reset = 1'b1;
      #1;
      chk("wrst_raddr_clr", mem_raddr[2], 32'h0);
      chk("wrst_outs_after", outs(2), 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         step();
         #1;
         if (lsu_resp_valid[2] || ifu_resp_valid[2]) seen = 1'b1;
      end
      chk("wrst_no_resp", seen, 0);
      step();
      lsu_req_valid[2] = 1'b1;
      lsu_req_addr[2]  = 32'h8000_0000;
      #1;
      chk("fresh_ready", lsu_req_ready[2], 1);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 1) lsu_req_valid[2] = 1'b0;
         #1;
         if (lsu_resp_valid[2]) begin
            lat = c;
            break;
         end
      end
      chk("fresh_latency", lat, 8);
      chk("fresh_data", lsu_resp_data[2], 32'h0000_0413);
      step();
      lsu_resp_ready[2] = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single DPI load/store memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Requesters use valid/ready request and response channels.
- The block drives the one-cycle load/store strobes, captures read data, and inserts a configurable wait latency to emulate slow memory.
- Sits between IFU/LSU and the DPI memory access module in the npc core.

Parameters:
- LATENCY, 0: extra wait cycles between data capture and response, range 0..255.
- RR_ARB, 1: 1 = round-robin arbitration; 0 = fixed priority, LSU over IFU.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ifu_req_valid  in  1  IFU read request valid
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  32  IFU read address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU can take response
- ifu_resp_data  out  32  IFU read data
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_addr  in  32  LSU address
- lsu_req_wdata  in  32  store data
- lsu_req_wmask  in  8  store byte mask
- lsu_resp_valid  out  1  LSU response valid (loads and stores)
- lsu_resp_ready  in  1  LSU can take response
- lsu_resp_data  out  32  load data; 0 for stores
- mem_ld_wen  out  1  load strobe to memory port
- mem_st_wen  out  1  store strobe to memory port
- mem_raddr  out  32  memory read address
- mem_waddr  out  32  memory write address
- mem_wdata  out  32  memory write data
- mem_wmask  out  8  memory write mask
- mem_rdata  in  32  memory read data, valid the cycle after the load strobe edge

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. While reset=0:
  - state goes to IDLE; counter, data buffer, grant latch, last_grant (=IFU) and all mem_* registers clear to 0.
  - All valid/ready/strobe outputs are 0.
  - An in-flight transaction is dropped with no response and no further strobe.
- States:
  - IDLE: only state with req_ready possible.
    - Grant is chosen combinationally. *_req_ready=1 only for the granted requester, and only if its valid=1.
    - Handshake is valid&&ready. On handshake, latch requester id, addr, wen, wdata, wmask; go to ISSUE.
  - ISSUE (1 cycle): mem_ld_wen=!wen or mem_st_wen=wen, driven from registers. mem_raddr and mem_waddr both equal the latched addr. Next state: CAPT.
  - CAPT (1 cycle): if load, capture mem_rdata into the data buffer; if store, buffer=0. Next state: WAIT if LATENCY>0, else RESP. The 8-bit counter loads LATENCY-1.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: assert owner's resp_valid with resp_data=buffer. Hold valid and data stable until resp_ready=1, then go to IDLE.
- Strobes:
  - Exactly one strobe pulse per accepted request, never both.
  - Strobes are 0 in all states except ISSUE.
  - mem_* address/data registers hold their last value outside ISSUE.
- Latency: handshake in cycle T → strobe in T+1 → resp_valid from cycle T+3+LATENCY. Non-owner resp_valid is always 0.
- Arbitration:
  - Both valid with RR_ARB=1: grant the requester that is not last_grant. last_grant updates on each handshake.
  - Only one valid: grant it, regardless of mode.
  - RR_ARB=0: LSU always wins; IFU may starve (by design).
- No new request is accepted until the response handshake completes (single outstanding transaction). A new request may be accepted in the cycle after RESP exits.
- Request inputs may change freely after handshake, because all fields are latched.

Test Plan:
- IFU read only, addr=0x80000000, memory returns 0x00000413, LATENCY=0:
  - ifu_req_ready=1 in cycle 0; mem_ld_wen=1 only in cycle 1 with mem_raddr=0x80000000.
  - ifu_resp_valid=1 from cycle 3 with data 0x00000413.
- LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F:
  - Single mem_st_wen pulse with exactly those values; mem_ld_wen stays 0.
  - lsu_resp_valid with data 0; memory word reads back 0xDEADBEEF.
- Both valid every cycle, RR_ARB=1, starting from reset: grants alternate LSU, IFU, LSU, IFU. With RR_ARB=0: four consecutive LSU grants and no IFU grant.
- LATENCY=5, resp_ready held 0 for 4 cycles after resp_valid rises:
  - resp_valid rises at T+8 and stays high with stable data until the ready cycle.
  - No req_ready is asserted meanwhile.
- reset=0 during WAIT:
  - Next cycle state is IDLE with all outputs 0; no response is ever produced.
  - A fresh request after reset completes normally.
